// File: rtl/icache_pkg.sv
// Shared field widths, positions and FSM state encoding for the instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_pkg;

  localparam int MEM_ADDR_W   = 10;
  localparam int INDEX_W      = 3;
  localparam int WORDS_PER_BL = 4;
  localparam int OFFSET_W     = 2;
  localparam int TAG_W        = MEM_ADDR_W - INDEX_W - 4;
  localparam int BLK_ADDR_W   = TAG_W + INDEX_W;
  localparam int NUM_LINES    = 2 ** INDEX_W;
  localparam int WORD_W       = 32;
  localparam int BLOCK_W      = WORD_W * WORDS_PER_BL;

  // Byte-address field positions: [TAG | INDEX | OFFSET | 2'b00]
  localparam int OFFSET_LSB   = 2;
  localparam int INDEX_LSB    = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_W;

  typedef logic [INDEX_W-1:0]    index_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [OFFSET_W-1:0]   offset_t;
  typedef logic [BLK_ADDR_W-1:0] blk_addr_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [BLOCK_W-1:0]    block_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  // Word 0 sits in the low 32 bits of a block.
  function automatic word_t select_word(input block_t blk, input offset_t off);
    return blk[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Latency: read port combinational; write lands on the rising edge with we_i=1.
// Backpressure: none; a write is always accepted. Reset clears valid bits only.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset (valid bits only)
//   rd_index_i            line to read; rd_valid_o/rd_tag_o/rd_block_o follow combinationally
//   we_i, wr_index_i,     line fill: block, tag and valid=1 written together
//   wr_tag_i, wr_block_i
module icache_array
  import icache_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  index_t rd_index_i,
  output logic   rd_valid_o,
  output tag_t   rd_tag_o,
  output block_t rd_block_o,
  input  logic   we_i,
  input  index_t wr_index_i,
  input  tag_t   wr_tag_i,
  input  block_t wr_block_i
);

  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  block_t               data_q [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag/data carry no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_block_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_block_o = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped 8-line x 4-word instruction cache in front of the PC fetch path.
// Latency: zero-cycle hit; a miss with N memory-busy cycles stalls for N+2 cycles after the miss cycle.
// Backpressure: BUSYWAIT stalls the PC on a miss; memory side waits on MEM_BUSYWAIT while MEM_READ is held.
//
// Ports:
//   CLK, RESET          clock, synchronous active-low reset
//   ADDRESS             PC byte address (only [9:2] used)
//   INSTRUCTION         fetched word, valid when BUSYWAIT=0
//   BUSYWAIT            stall request to the PC
//   MEM_READ            block read request, high for the whole MEM_READ state
//   MEM_ADDRESS         latched block address {tag,index} of the missing block
//   MEM_READDATA        128-bit block, word0 in [31:0]
//   MEM_BUSYWAIT        memory busy; data taken on the edge it is sampled low
module instruction_cache
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           ADDRESS,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_e    state_q, state_d;
  blk_addr_t mem_addr_q, mem_addr_d;
  block_t    fill_q, fill_d;

  offset_t addr_off;
  index_t  addr_index;
  tag_t    addr_tag;
  logic    unused_addr_bits;

  logic    rd_valid;
  tag_t    rd_tag;
  block_t  rd_block;
  logic    hit;
  logic    array_we;

  assign addr_off   = ADDRESS[OFFSET_LSB +: OFFSET_W];
  assign addr_index = ADDRESS[INDEX_LSB  +: INDEX_W];
  assign addr_tag   = ADDRESS[TAG_LSB    +: TAG_W];
  // Upper PC bits fall outside the instruction memory; low two are always 0.
  assign unused_addr_bits = ^{ADDRESS[31:MEM_ADDR_W], ADDRESS[OFFSET_LSB-1:0]};

  icache_array u_array (
    .clk_i      (CLK),
    .rst_n_i    (RESET),
    .rd_index_i (addr_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_block_o (rd_block),
    .we_i       (array_we),
    .wr_index_i (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i   (mem_addr_q[BLK_ADDR_W-1:INDEX_W]),
    .wr_block_i (fill_q)
  );

  assign hit = rd_valid && (rd_tag == addr_tag);

  // Fill always targets the latched block address, so PC wander during a
  // refill cannot redirect the write.
  assign array_we = (state_q == ST_UPDATE);

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fill_d     = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          state_d    = ST_MEM_READ;
          mem_addr_d = {addr_tag, addr_index};
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          state_d = ST_UPDATE;
          fill_d  = MEM_READDATA;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
  end

  assign MEM_READ    = (state_q == ST_MEM_READ);
  assign MEM_ADDRESS = mem_addr_q;

  // In IDLE the stall follows the hit comparison directly, giving the
  // zero-cycle hit and the same-cycle stall on a miss.
  assign BUSYWAIT    = RESET && ((state_q != ST_IDLE) || !hit);
  assign INSTRUCTION = RESET ? select_word(rd_block, addr_off) : '0;

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int vectors = 0;
  int errors  = 0;
  int mem_lat = 0;
  int mem_cnt = 0;

  logic [31:0] exp_q[$];

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents: every word is unique per (block, word).
  function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] w);
    return {24'hC0DE00, b, w};
  endfunction

  // Memory responder: busy for mem_lat edges of MEM_READ, then ready.
  assign MEM_READDATA = {mem_word(MEM_ADDRESS, 2'd3), mem_word(MEM_ADDRESS, 2'd2),
                         mem_word(MEM_ADDRESS, 2'd1), mem_word(MEM_ADDRESS, 2'd0)};
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);

  always @(posedge CLK) begin
    if (!MEM_READ) mem_cnt <= 0;
    else if (mem_cnt < mem_lat) mem_cnt <= mem_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // One fetch from an idle cache: miss/hit on the first cycle, then for a
  // miss the request, latched block address and stall length counted from
  // the first MEM_READ cycle (N busy cycles -> N+2).
  task automatic fetch(input logic [31:0] a, input bit exp_miss, input int lat);
    int stall;
    mem_lat = lat;
    ADDRESS = a;
    exp_q.push_back(mem_word(a[9:4], a[3:2]));
    #3;
    check("busy_first", 32'(BUSYWAIT), 32'(exp_miss));
    if (exp_miss) begin
      cyc(); #3;
      check("mem_read", 32'(MEM_READ), 32'd1);
      check("mem_addr", 32'(MEM_ADDRESS), 32'(a[9:4]));
      stall = 0;
      while (BUSYWAIT === 1'b1 && stall < 100) begin
        stall++;
        cyc(); #3;
      end
      check("stall_len", 32'(stall), 32'(lat + 2));
    end
    check("instr", INSTRUCTION, exp_q.pop_front());
    cyc();
  endtask

  initial begin
    int stall;
    RESET   = 1'b0;
    ADDRESS = 32'h0;
    cyc(); cyc(); #3;
    check("rst_busy",  32'(BUSYWAIT),    32'd0);
    check("rst_instr", INSTRUCTION,      32'd0);
    check("rst_mread", 32'(MEM_READ),    32'd0);
    check("rst_maddr", 32'(MEM_ADDRESS), 32'd0);
    cyc();
    RESET = 1'b1;

    // Cold miss with 5 busy cycles, then hits across the same line.
    fetch(32'h000, 1'b1, 5);
    fetch(32'h004, 1'b0, 0);
    fetch(32'h008, 1'b0, 0);
    fetch(32'h00C, 1'b0, 0);

    // Conflict on index 0: tag 1 evicts tag 0, which then misses again.
    fetch(32'h080, 1'b1, 2);
    fetch(32'h084, 1'b0, 0);
    fetch(32'h000, 1'b1, 1);

    // PC reset value; memory ready on the first MEM_READ edge.
    fetch(32'hFFFF_FFFC, 1'b1, 0);
    fetch(32'h0000_03F0, 1'b0, 0);

    // PC moves during a refill: the fill must use the latched block.
    mem_lat = 3;
    ADDRESS = 32'h010;
    exp_q.push_back(mem_word(6'h01, 2'd0));
    #3;
    check("chg_busy", 32'(BUSYWAIT), 32'd1);
    cyc();
    ADDRESS = 32'h020;
    #3;
    check("chg_maddr0", 32'(MEM_ADDRESS), 32'h01);
    cyc(); #3;
    check("chg_maddr1", 32'(MEM_ADDRESS), 32'h01);
    cyc();
    ADDRESS = 32'h010;
    stall = 0;
    #3;
    while (BUSYWAIT === 1'b1 && stall < 100) begin
      stall++;
      cyc(); #3;
    end
    check("chg_done", 32'(stall < 100), 32'd1);
    check("chg_instr", INSTRUCTION, exp_q.pop_front());
    cyc();
    fetch(32'h020, 1'b1, 1);
    fetch(32'h014, 1'b0, 0);

    // Reset in the middle of a refill abandons it and clears the valid bits.
    mem_lat = 10;
    ADDRESS = 32'h030;
    #3;
    check("mid_busy", 32'(BUSYWAIT), 32'd1);
    cyc(); #3;
    check("mid_mread", 32'(MEM_READ), 32'd1);
    cyc();
    RESET = 1'b0;
    #3;
    check("mid_rst_busy",  32'(BUSYWAIT), 32'd0);
    check("mid_rst_instr", INSTRUCTION,   32'd0);
    cyc(); #3;
    check("mid_rst_mread", 32'(MEM_READ),    32'd0);
    check("mid_rst_maddr", 32'(MEM_ADDRESS), 32'd0);
    cyc();
    RESET = 1'b1;
    fetch(32'h000, 1'b1, 0);
    fetch(32'h030, 1'b1, 2);
    fetch(32'h03C, 1'b0, 0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
